// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared constants and types for the CPU fetch stage
package cpu_fetch_pkg;

    localparam int          CPU_W_ADDR       = 16;
    localparam logic [15:0] CPU_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] CPU_IRQ_VECTOR   = 16'h0100;
    localparam logic [15:0] CPU_NOP_INSN     = 16'h0000;

    // Which source supplies the next fetch PC, highest priority first after SEQ
    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_IRET = 2'd2,
        SEL_IRQ  = 2'd3
    } redirect_e;

endpackage

// File: rtl/cpu_pc_sel.sv
// rtl/cpu_pc_sel.sv - combinational priority redirect mux for the fetch PC
module cpu_pc_sel
    import cpu_fetch_pkg::*;
#(
    parameter int                W_ADDR     = CPU_W_ADDR,
    parameter logic [W_ADDR-1:0] IRQ_VECTOR = W_ADDR'(CPU_IRQ_VECTOR)
) (
    input  logic              i_br_taken,
    input  logic [W_ADDR-1:0] i_br_target,
    input  logic              i_iret,
    input  logic              i_irq_req,
    input  logic              i_in_irq,
    input  logic [W_ADDR-1:0] i_pc_f,
    input  logic [W_ADDR-1:0] i_ret_pc,
    output logic [W_ADDR-1:0] o_next_pc,
    output logic              o_annul,
    output logic              o_irq_take,
    output logic              o_iret_take
);

    redirect_e         w_sel;
    logic [W_ADDR-1:0] w_target;

    // Instructions are halfword aligned, so the target's low bit is dropped
    assign w_target = i_br_target & {{(W_ADDR-1){1'b1}}, 1'b0};

    // Branch beats IRQ return beats IRQ entry; IRQ return and entry are
    // only meaningful on the matching side of the in-handler flag
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_br_taken) begin
            w_sel = SEL_BR;
        end else if (i_iret && i_in_irq) begin
            w_sel = SEL_IRET;
        end else if (i_irq_req && !i_in_irq) begin
            w_sel = SEL_IRQ;
        end
    end

    // Next fetch address for the chosen source; sequential wraps modulo 2^W_ADDR
    always_comb begin
        o_next_pc = i_pc_f + W_ADDR'(2);
        case (w_sel)
            SEL_BR:   o_next_pc = w_target;
            SEL_IRET: o_next_pc = i_ret_pc;
            SEL_IRQ:  o_next_pc = IRQ_VECTOR;
            default:  o_next_pc = i_pc_f + W_ADDR'(2);
        endcase
    end

    assign o_annul     = (w_sel != SEL_SEQ);
    assign o_irq_take  = (w_sel == SEL_IRQ);
    assign o_iret_take = (w_sel == SEL_IRET);

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch stage: fetch PC, instruction register, IRQ entry/return
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int                W_ADDR       = CPU_W_ADDR,
    parameter logic [W_ADDR-1:0] RESET_VECTOR = W_ADDR'(CPU_RESET_VECTOR),
    parameter logic [W_ADDR-1:0] IRQ_VECTOR   = W_ADDR'(CPU_IRQ_VECTOR),
    parameter logic [15:0]       NOP_INSN     = CPU_NOP_INSN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_insn_ce,
    input  logic              i_br_taken,
    input  logic [W_ADDR-1:0] i_br_target,
    input  logic              i_irq_req,
    input  logic              i_iret,
    output logic [W_ADDR-1:0] o_imem_addr,
    input  logic [15:0]       i_imem_data,
    output logic [15:0]       o_insn_q,
    output logic [W_ADDR-1:0] o_pc,
    output logic              o_in_irq,
    output logic              o_irq_ack
);

    logic [W_ADDR-1:0] r_pc_f;
    logic [W_ADDR-1:0] r_pc;
    logic [W_ADDR-1:0] r_ret_pc;
    logic [15:0]       r_insn_q;
    logic              r_in_irq;
    logic              r_irq_ack;

    logic [W_ADDR-1:0] w_next_pc;
    logic              w_annul;
    logic              w_irq_take;
    logic              w_iret_take;

    cpu_pc_sel #(
        .W_ADDR     (W_ADDR),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) u_pc_sel (
        .i_br_taken  (i_br_taken),
        .i_br_target (i_br_target),
        .i_iret      (i_iret),
        .i_irq_req   (i_irq_req),
        .i_in_irq    (r_in_irq),
        .i_pc_f      (r_pc_f),
        .i_ret_pc    (r_ret_pc),
        .o_next_pc   (w_next_pc),
        .o_annul     (w_annul),
        .o_irq_take  (w_irq_take),
        .o_iret_take (w_iret_take)
    );

    // Advance the stage when enabled; a redirect squashes the word fetched this cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc_f    <= RESET_VECTOR;
            r_pc      <= RESET_VECTOR;
            r_ret_pc  <= '0;
            r_insn_q  <= NOP_INSN;
            r_in_irq  <= 1'b0;
            r_irq_ack <= 1'b0;
        end else if (i_insn_ce) begin
            r_pc_f    <= w_next_pc;
            r_pc      <= r_pc_f;
            r_insn_q  <= w_annul ? NOP_INSN : i_imem_data;
            r_irq_ack <= w_irq_take;
            if (w_irq_take) begin
                // The annulled word is the first one the handler must resume at
                r_ret_pc <= r_pc_f;
                r_in_irq <= 1'b1;
            end else if (w_iret_take) begin
                r_in_irq <= 1'b0;
            end
        end else begin
            r_irq_ack <= 1'b0;
        end
    end

    assign o_imem_addr = r_pc_f;
    assign o_insn_q    = r_insn_q;
    assign o_pc        = r_pc;
    assign o_in_irq    = r_in_irq;
    assign o_irq_ack   = r_irq_ack;

endmodule
